// File: rtl/pcileech_pkg.sv
// Shared constants for the PCIeScreamer transmit datapath.
// Beat geometry and the filler word used when a partial beat is flushed.
package pcileech_pkg;

    localparam int          PCILEECH_TX_WORDS_PER_BEAT = 8;
    localparam int          PCILEECH_TX_BEAT_WIDTH     = 256;
    localparam logic [31:0] PCILEECH_PAD_WORD          = 32'h66665555;

endpackage

// File: rtl/pcileech_tx_pack256.sv
// Packs eight 32-bit transmit words into one 256-bit vFIFO write, padding and
// flushing a partial beat after an idle timeout; never writes on adjacent clocks.
module pcileech_tx_pack256
    import pcileech_pkg::*;
#(
    parameter int          PARAM_FLUSH_CYCLES = 64,
    parameter logic [31:0] PARAM_PAD_WORD     = PCILEECH_PAD_WORD
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [PCILEECH_TX_BEAT_WIDTH-1:0] dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              flush_pulse
);

    localparam logic [15:0] IDLE_LAST  = 16'(PARAM_FLUSH_CYCLES - 1);
    localparam logic [3:0]  COUNT_FULL = 4'(PCILEECH_TX_WORDS_PER_BEAT);

    logic [31:0]                       acc_r [PCILEECH_TX_WORDS_PER_BEAT];
    logic [3:0]                        count_r;
    logic [PCILEECH_TX_BEAT_WIDTH-1:0] obuf_r;
    logic                              ofull_r;
    logic [15:0]                       idle_r;
    logic                              gap_r;
    logic                              flush_pulse_r;

    logic                              xfer_s;
    logic                              full_cond_s;
    logic                              flush_cond_s;
    logic                              obuf_free_s;
    logic                              move_s;
    logic                              flush_move_s;
    logic [15:0]                       idle_next_s;
    logic [PCILEECH_TX_BEAT_WIDTH-1:0] beat_s;

    assign din_ready   = (count_r != COUNT_FULL);
    assign xfer_s      = din_valid & din_ready;
    assign dout        = obuf_r;
    assign dout_valid  = ofull_r & dout_ready & ~gap_r;
    assign flush_pulse = flush_pulse_r;

    // A full accumulator (or the word that fills it) wins over a timeout.
    assign full_cond_s  = (count_r == COUNT_FULL) || (xfer_s && (count_r == 4'd7));
    assign flush_cond_s = (count_r != 4'd0) && !xfer_s && (idle_r == IDLE_LAST);
    assign obuf_free_s  = !ofull_r || dout_valid;
    assign move_s       = obuf_free_s && (full_cond_s || flush_cond_s);
    assign flush_move_s = move_s && flush_cond_s && !full_cond_s;

    // Beat image: stored words, the word arriving this cycle, then filler.
    always_comb begin
        beat_s = '0;
        for (int i = 0; i < PCILEECH_TX_WORDS_PER_BEAT; i++) begin
            if (4'(i) < count_r) begin
                beat_s[32*i +: 32] = acc_r[i];
            end else if (xfer_s && (4'(i) == count_r)) begin
                beat_s[32*i +: 32] = din;
            end else begin
                beat_s[32*i +: 32] = PARAM_PAD_WORD;
            end
        end
    end

    // Idle counter saturates at the timeout so a blocked flush fires once obuf frees.
    always_comb begin
        idle_next_s = idle_r;
        if (xfer_s || move_s) begin
            idle_next_s = 16'd0;
        end else if (count_r == 4'd0) begin
            idle_next_s = 16'd0;
        end else if (idle_r != IDLE_LAST) begin
            idle_next_s = idle_r + 16'd1;
        end else begin
            idle_next_s = idle_r;
        end
    end

    // Accumulator, output buffer and pacing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PCILEECH_TX_WORDS_PER_BEAT; i++) begin
                acc_r[i] <= 32'd0;
            end
            count_r       <= 4'd0;
            obuf_r        <= '0;
            ofull_r       <= 1'b0;
            idle_r        <= 16'd0;
            gap_r         <= 1'b0;
            flush_pulse_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                acc_r[count_r[2:0]] <= din;
            end
            if (move_s) begin
                count_r <= 4'd0;
            end else if (xfer_s) begin
                count_r <= count_r + 4'd1;
            end
            if (move_s) begin
                obuf_r  <= beat_s;
                ofull_r <= 1'b1;
            end else if (dout_valid) begin
                ofull_r <= 1'b0;
            end
            idle_r        <= idle_next_s;
            gap_r         <= dout_valid;
            flush_pulse_r <= flush_move_s;
        end
    end

endmodule

// File: doc/pcileech_tx_pack256.md
# pcileech_tx_pack256

Width-converting packer between the 32-bit FIFO-control transmit stream and the 256-bit vFIFO write port on the PCIeScreamer datapath. Collects eight 32-bit words into one 256-bit beat and writes it to the DDR3-backed vFIFO. Observes the vFIFO rule that valid is never asserted on two consecutive clocks. A partially filled beat is padded and flushed after a configurable idle time, so short responses reach the FT601 host without waiting for more traffic.

## Interface
Parameters:
- PARAM_FLUSH_CYCLES, default 64: idle cycles with a partial beat before a padded flush; legal range 1..65535.
- PARAM_PAD_WORD, default 32'h66665555: filler written into unused word slots on a flush.

Ports:
- clk, in, 1: system clock, 100 MHz. One clock; every element sits in this domain.
- rst, in, 1: reset, synchronous, active-high.
- din, in, 32: transmit word from FIFO control.
- din_valid, in, 1: din is valid this cycle.
- din_ready, out, 1: packer accepts din this cycle. A transfer occurs when din_valid & din_ready.
- dout, out, 256: packed beat to vFIFO. Word 0 (first received) is in bits [31:0]; word i is in bits [32i+31:32i].
- dout_valid, out, 1: single-cycle write strobe to vFIFO. Every cycle it is high is one write.
- dout_ready, in, 1: vFIFO can accept a write this cycle.
- flush_pulse, out, 1: one-cycle pulse when a padded (partial) beat is moved to the output register; used for debug/LED.

## Operation
- Storage: accumulator acc[0..7] of 32-bit words plus a 4-bit count (0..8); output register obuf (256-bit) plus flag ofull; idle counter idle_cnt, 16-bit; register gap_q.
- Accept: on a din transfer, write acc[count] <= din and increment count.
- Move: acc contents go to obuf and count clears, on the same edge, when either condition holds:
  - count becomes 8, or count already equals 8;
  - the flush condition holds.
  - In both cases obuf must be free: ofull=0, or obuf is being written out this cycle.
- Flush: when count>0, no din transfer this cycle, and idle_cnt == PARAM_FLUSH_CYCLES-1, slots count..7 are filled with PARAM_PAD_WORD and the move occurs. flush_pulse=1 on that edge.
- Flush blocked: if obuf is occupied when the flush condition holds, idle_cnt saturates and the flush occurs on the first cycle obuf frees.
- idle_cnt: clears on any din transfer or any move; increments while count>0 and idle; holds at 0 while count==0.
- din_ready = (count != 8). It is deasserted only while acc is full and waiting for obuf.
- Output: dout = obuf. dout_valid = ofull & dout_ready & ~gap_q (combinational from registers and dout_ready). gap_q <= dout_valid. ofull clears on the edge where dout_valid=1 unless a move refills it on the same edge.
- Simultaneous events:
  - A din transfer in the same cycle as a timeout: the accept wins, no flush, and idle_cnt clears.
  - The 8th word accepted while obuf is draining: the move happens on the same edge, with no bubble.
- Empty: count==0 never flushes and never emits an all-pad beat.

## Timing
- Reset values: din_ready=1, dout_valid=0, dout=0, flush_pulse=0. Internally count=0, ofull=0, gap_q=0, idle_cnt=0.
- Reset mid-operation drops all accumulated and buffered data. No partial beat is emitted afterwards.
- Latency: 8th word accepted at edge k sets ofull at edge k. dout_valid can rise in cycle k+1 if dout_ready=1.
- Throughput: at most one beat per 2 cycles (the gap rule), well above the input rate of one beat per 8 cycles.
- Flush latency: last word at edge k; flush edge at k+PARAM_FLUSH_CYCLES with obuf free; dout_valid in the following cycle.
- dout_valid never high on two consecutive cycles; dout is stable while ofull=1.

## Structure
- Shared package pcileech_pkg holds:
  - PCILEECH_PAD_WORD (32'h66665555);
  - PCILEECH_TX_WORDS_PER_BEAT (8) and the beat width (256).
- Single module; no sub-module is warranted. The idle counter and accumulator are a few registers each.

## Test plan
- Stream 8 words 0x00000001..0x00000008 with dout_ready=1 -> exactly one dout_valid, dout = 0x00000008_..._00000001 (word 0 in [31:0]), one cycle after the 8th accept.
- Send 3 words 0xA0..0xA2, then idle, with PARAM_FLUSH_CYCLES=64 -> flush_pulse on the 64th idle edge. Next cycle dout = {5×0x66665555, 0xA2, 0xA1, 0xA0} and dout_valid=1.
- Send 24 back-to-back words with dout_ready=1 -> 3 beats, dout_valid never high on adjacent cycles, din_ready stays 1.
- Hold dout_ready=0 and send 17 words -> din_ready drops after the 16th accept (obuf and acc full). Release ready -> beats 1 and 2 emitted ≥2 cycles apart, then word 17 accepted.
- Partial beat of 2 words with obuf full and dout_ready=0 past the timeout -> no flush until ready=1, then obuf emits and the padded beat follows with one gap cycle.
- Assert rst for 1 cycle with 5 words in acc and obuf full -> all outputs at reset values, no dout_valid afterwards without new input.
